// File: rtl/mac_tile.sv
// COL-column systolic dot-product tile: per-column K registers, skewed Q token chain,
// two-stage multiply / adder-tree pipeline per column with accumulate, emit and stall.
module mac_tile #(
   parameter int COL     = 8,
   parameter int PR      = 8,
   parameter int BW      = 8,
   parameter int BW_PSUM = 22
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [BW*PR-1:0]         in,
   input  logic [1:0]               inst,
   input  logic                     sign_mode,
   input  logic                     stall,
   output logic [BW_PSUM*COL-1:0]   out,
   output logic [COL-1:0]           fifo_wr,
   output logic                     k_loaded,
   output logic                     busy
);

   localparam int PTR_W = (COL > 1) ? $clog2(COL) : 1;
   localparam logic [1:0] INST_LOAD = 2'b01;

   logic [BW*PR-1:0]     weight_q    [COL];
   logic [BW*PR-1:0]     weight_d    [COL];
   logic [BW*PR-1:0]     tok_data_q  [COL];
   logic [BW*PR-1:0]     tok_data_d  [COL];
   logic [COL-1:0]       tok_vld_q, tok_vld_d;
   logic [COL-1:0]       tok_acc_q, tok_acc_d;
   logic [COL-1:0]       tok_sgn_q, tok_sgn_d;
   logic [2*BW*PR-1:0]   prod_q      [COL];
   logic [2*BW*PR-1:0]   prod_d      [COL];
   logic [COL-1:0]       prod_vld_q, prod_vld_d;
   logic [COL-1:0]       prod_acc_q, prod_acc_d;
   logic [COL-1:0]       prod_sgn_q, prod_sgn_d;
   logic [BW_PSUM-1:0]   acc_q       [COL];
   logic [BW_PSUM-1:0]   acc_d       [COL];
   logic [BW_PSUM-1:0]   out_q       [COL];
   logic [BW_PSUM-1:0]   out_d       [COL];
   logic [BW_PSUM-1:0]   sum_s       [COL];
   logic [COL-1:0]       wr_q, wr_d;
   logic [PTR_W-1:0]     ptr_q, ptr_d;
   logic                 kl_q, kl_d;
   logic                 busy_s;

   // Low 2*BW bits of the product of operands extended per sign mode equal the exact product.
   function automatic logic [2*BW-1:0] mul_lane(input logic [BW-1:0] a,
                                                input logic [BW-1:0] b,
                                                input logic sgn);
      logic [2*BW-1:0] ae;
      logic [2*BW-1:0] be;
      ae = {{BW{sgn & a[BW-1]}}, a};
      be = {{BW{sgn & b[BW-1]}}, b};
      return ae * be;
   endfunction

   function automatic logic [2*BW*PR-1:0] lane_products(input logic [BW*PR-1:0] q,
                                                        input logic [BW*PR-1:0] k,
                                                        input logic sgn);
      logic [2*BW*PR-1:0] r;
      r = '0;
      for (int i = 0; i < PR; i++) begin
         r[2*BW*i +: 2*BW] = mul_lane(q[BW*i +: BW], k[BW*i +: BW], sgn);
      end
      return r;
   endfunction

   function automatic logic [BW_PSUM-1:0] dot_sum(input logic [2*BW*PR-1:0] p,
                                                  input logic sgn);
      logic [BW_PSUM-1:0] r;
      logic [2*BW-1:0]    lane;
      r = '0;
      for (int i = 0; i < PR; i++) begin
         lane = p[2*BW*i +: 2*BW];
         r = r + {{(BW_PSUM-2*BW){sgn & lane[2*BW-1]}}, lane};
      end
      return r;
   endfunction

   // Any token in the chain, the product stage or a pending strobe keeps the tile busy.
   always_comb begin
      busy_s = (|tok_vld_q) | (|prod_vld_q) | (|wr_q);
   end

   // Stage-2 result per column: accumulator plus the adder-tree dot product.
   always_comb begin
      for (int c = 0; c < COL; c++) begin
         sum_s[c] = acc_q[c] + dot_sum(prod_q[c], prod_sgn_q[c]);
      end
   end

   // Next-state: everything holds under stall; otherwise load, shift tokens and run the stages.
   always_comb begin
      weight_d   = weight_q;
      tok_data_d = tok_data_q;
      tok_vld_d  = tok_vld_q;
      tok_acc_d  = tok_acc_q;
      tok_sgn_d  = tok_sgn_q;
      prod_d     = prod_q;
      prod_vld_d = prod_vld_q;
      prod_acc_d = prod_acc_q;
      prod_sgn_d = prod_sgn_q;
      acc_d      = acc_q;
      out_d      = out_q;
      wr_d       = wr_q;
      ptr_d      = ptr_q;
      kl_d       = kl_q;
      if (!stall) begin
         if ((inst == INST_LOAD) && !busy_s) begin
            weight_d[ptr_q] = in;
            if (ptr_q == PTR_W'(COL - 1)) begin
               ptr_d = '0;
               kl_d  = 1'b1;
            end else begin
               ptr_d = ptr_q + PTR_W'(1);
            end
         end else begin
            ptr_d = ptr_q;
         end
         tok_vld_d[0]  = inst[1];
         tok_acc_d[0]  = inst[0];
         tok_sgn_d[0]  = sign_mode;
         tok_data_d[0] = in;
         for (int c = 1; c < COL; c++) begin
            tok_vld_d[c]  = tok_vld_q[c-1];
            tok_acc_d[c]  = tok_acc_q[c-1];
            tok_sgn_d[c]  = tok_sgn_q[c-1];
            tok_data_d[c] = tok_data_q[c-1];
         end
         for (int c = 0; c < COL; c++) begin
            prod_d[c]     = lane_products(tok_data_q[c], weight_q[c], tok_sgn_q[c]);
            prod_vld_d[c] = tok_vld_q[c];
            prod_acc_d[c] = tok_acc_q[c];
            prod_sgn_d[c] = tok_sgn_q[c];
            wr_d[c]       = 1'b0;
            if (prod_vld_q[c]) begin
               if (prod_acc_q[c]) begin
                  acc_d[c] = sum_s[c];
               end else begin
                  out_d[c] = sum_s[c];
                  acc_d[c] = '0;
                  wr_d[c]  = 1'b1;
               end
            end else begin
               acc_d[c] = acc_q[c];
            end
         end
      end else begin
         kl_d = kl_q;
      end
   end

   // State registers with asynchronous clear.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int c = 0; c < COL; c++) begin
            weight_q[c]   <= '0;
            tok_data_q[c] <= '0;
            prod_q[c]     <= '0;
            acc_q[c]      <= '0;
            out_q[c]      <= '0;
         end
         tok_vld_q  <= '0;
         tok_acc_q  <= '0;
         tok_sgn_q  <= '0;
         prod_vld_q <= '0;
         prod_acc_q <= '0;
         prod_sgn_q <= '0;
         wr_q       <= '0;
         ptr_q      <= '0;
         kl_q       <= 1'b0;
      end else begin
         weight_q   <= weight_d;
         tok_data_q <= tok_data_d;
         prod_q     <= prod_d;
         acc_q      <= acc_d;
         out_q      <= out_d;
         tok_vld_q  <= tok_vld_d;
         tok_acc_q  <= tok_acc_d;
         tok_sgn_q  <= tok_sgn_d;
         prod_vld_q <= prod_vld_d;
         prod_acc_q <= prod_acc_d;
         prod_sgn_q <= prod_sgn_d;
         wr_q       <= wr_d;
         ptr_q      <= ptr_d;
         kl_q       <= kl_d;
      end
   end

   // Output mapping; a strobe held through a stall is shown once the stall drops.
   always_comb begin
      out = '0;
      for (int c = 0; c < COL; c++) begin
         out[BW_PSUM*c +: BW_PSUM] = out_q[c];
      end
      if (stall) begin
         fifo_wr = '0;
      end else begin
         fifo_wr = wr_q;
      end
      k_loaded = kl_q;
      busy     = busy_s;
   end

endmodule

// File: tb/tb_mac_tile.sv
// Directed self-checking bench for mac_tile (COL=4, PR=8, BW=8, BW_PSUM=22).
module tb_mac_tile;
   localparam int COL = 4, PR = 8, BW = 8, BW_PSUM = 22;

   logic                   clk = 1'b0;
   logic                   reset = 1'b0;
   logic [BW*PR-1:0]       in_v = '0;
   logic [1:0]             inst = 2'b00;
   logic                   sign_mode = 1'b0;
   logic                   stall = 1'b0;
   logic [BW_PSUM*COL-1:0] out_v;
   logic [COL-1:0]         fifo_wr;
   logic                   k_loaded;
   logic                   busy;

   int n_tests = 0;
   int n_fail  = 0;
   logic [BW_PSUM-1:0] got_val [COL];
   int                 got_cnt [COL];
   int                 got_at  [COL];

   mac_tile #(.COL(COL), .PR(PR), .BW(BW), .BW_PSUM(BW_PSUM)) dut (
      .clk(clk), .reset(reset), .in(in_v), .inst(inst), .sign_mode(sign_mode),
      .stall(stall), .out(out_v), .fifo_wr(fifo_wr), .k_loaded(k_loaded), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [BW_PSUM-1:0] col_out(input int c);
      return out_v[BW_PSUM*c +: BW_PSUM];
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] op, input logic [BW-1:0] v, input logic sgn);
      inst      = op;
      in_v      = {PR{v}};
      sign_mode = sgn;
   endtask

   task automatic load_vec(input logic [BW-1:0] v);
      drive(2'b01, v, 1'b0);
      step();
      drive(2'b00, 8'd0, 1'b0);
   endtask

   // Issue one emit and record per-column strobe count, last value and sample index.
   task automatic exec_one(input logic [BW-1:0] v, input logic sgn);
      for (int c = 0; c < COL; c++) begin
         got_cnt[c] = 0; got_val[c] = '0; got_at[c] = -1;
      end
      for (int n = 0; n < COL + 5; n++) begin
         if (n == 0) drive(2'b10, v, sgn); else drive(2'b00, 8'd0, 1'b0);
         #1;
         for (int c = 0; c < COL; c++) begin
            if (fifo_wr[c]) begin
               got_cnt[c]++; got_val[c] = col_out(c); got_at[c] = n;
            end
         end
         step();
      end
   endtask

   task automatic test_reset();
      drive(2'b00, 8'd0, 1'b0);
      stall = 1'b0;
      reset = 1'b0;
      step(); step();
      n_tests++; if (out_v !== '0) begin n_fail++; $display("FAIL reset out: got %h expected 0", out_v); end
      n_tests++; if (fifo_wr !== 4'b0000) begin n_fail++; $display("FAIL reset fifo_wr: got %b expected 0000", fifo_wr); end
      n_tests++; if (k_loaded !== 1'b0) begin n_fail++; $display("FAIL reset k_loaded: got %b expected 0", k_loaded); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b expected 0", busy); end
      reset = 1'b1;
      step();
   endtask

   task automatic test_load_exec();
      for (int c = 0; c < COL; c++) begin
         load_vec(8'(c + 1));
         if (c == 2) begin
            n_tests++; if (k_loaded !== 1'b0) begin n_fail++; $display("FAIL k_loaded early: got %b expected 0", k_loaded); end
         end
      end
      n_tests++; if (k_loaded !== 1'b1) begin n_fail++; $display("FAIL k_loaded after 4 loads: got %b expected 1", k_loaded); end
      exec_one(8'd2, 1'b0);
      for (int c = 0; c < COL; c++) begin
         n_tests++; if (got_cnt[c] !== 1) begin n_fail++; $display("FAIL load_exec count col%0d: got %0d expected 1", c, got_cnt[c]); end
         n_tests++; if (got_val[c] !== 22'(16 * (c + 1))) begin n_fail++; $display("FAIL load_exec value col%0d: got %0d expected %0d", c, got_val[c], 16 * (c + 1)); end
         n_tests++; if (got_at[c] !== c + 3) begin n_fail++; $display("FAIL load_exec latency col%0d: got %0d expected %0d", c, got_at[c], c + 3); end
      end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy after drain: got %b expected 0", busy); end
   endtask

   task automatic test_signed();
      load_vec(8'hFF);
      exec_one(8'h7F, 1'b1);
      n_tests++; if (got_val[0] !== 22'h3FFC08) begin n_fail++; $display("FAIL signed col0: got %h expected 3ffc08", got_val[0]); end
      n_tests++; if (got_at[0] !== 3) begin n_fail++; $display("FAIL signed latency: got %0d expected 3", got_at[0]); end
      exec_one(8'h7F, 1'b0);
      n_tests++; if (got_val[0] !== 22'd259080) begin n_fail++; $display("FAIL unsigned col0: got %0d expected 259080", got_val[0]); end
   endtask

   task automatic test_accumulate();
      logic exp;
      for (int c = 0; c < COL; c++) load_vec(8'd1);
      for (int n = 0; n < 12; n++) begin
         case (n)
            0, 1:    drive(2'b11, 8'd1, 1'b0);
            2, 3:    drive(2'b10, 8'd1, 1'b0);
            default: drive(2'b00, 8'd0, 1'b0);
         endcase
         #1;
         for (int c = 0; c < COL; c++) begin
            exp = (n == c + 5) || (n == c + 6);
            n_tests++; if (fifo_wr[c] !== exp) begin n_fail++; $display("FAIL accum strobe col%0d n%0d: got %b expected %b", c, n, fifo_wr[c], exp); end
            if (n == c + 5) begin
               n_tests++; if (col_out(c) !== 22'd24) begin n_fail++; $display("FAIL accum sum col%0d: got %0d expected 24", c, col_out(c)); end
            end
            if (n == c + 6) begin
               n_tests++; if (col_out(c) !== 22'd8) begin n_fail++; $display("FAIL accum cleared col%0d: got %0d expected 8", c, col_out(c)); end
            end
         end
         step();
      end
   endtask

   task automatic test_back_to_back_stall();
      int j;
      int k;
      logic exp;
      for (int n = 0; n < 18; n++) begin
         stall = (n >= 3) && (n <= 5);
         j = (n < 3) ? n : n - 3;
         if (stall) drive(2'b10, 8'h55, 1'b0);
         else if (j < 6) drive(2'b10, 8'(j + 1), 1'b0);
         else drive(2'b00, 8'd0, 1'b0);
         #1;
         for (int c = 0; c < COL; c++) begin
            k = n - c - 6;
            exp = (k >= 0) && (k < 6);
            n_tests++; if (fifo_wr[c] !== exp) begin n_fail++; $display("FAIL stall strobe col%0d n%0d: got %b expected %b", c, n, fifo_wr[c], exp); end
            if (exp) begin
               n_tests++; if (col_out(c) !== 22'(8 * (k + 1))) begin n_fail++; $display("FAIL stall value col%0d n%0d: got %0d expected %0d", c, n, col_out(c), 8 * (k + 1)); end
            end
         end
         if (n == 14) begin
            n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL busy at last strobe: got %b expected 1", busy); end
         end
         if (n == 15) begin
            n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy after last strobe: got %b expected 0", busy); end
         end
         step();
      end
      stall = 1'b0;
   endtask

   task automatic test_reset_midstream();
      drive(2'b10, 8'd1, 1'b0);
      step();
      drive(2'b00, 8'd0, 1'b0);
      step();
      #1;
      n_tests++; if (busy !== 1'b1 || k_loaded !== 1'b1) begin n_fail++; $display("FAIL pre-reset busy/k_loaded: got %b%b expected 11", busy, k_loaded); end
      n_tests++; if (out_v === '0) begin n_fail++; $display("FAIL pre-reset out: got 0 expected nonzero"); end
      reset = 1'b0;
      #1;
      n_tests++; if (out_v !== '0) begin n_fail++; $display("FAIL async reset out: got %h expected 0", out_v); end
      n_tests++; if (fifo_wr !== 4'b0000 || busy !== 1'b0 || k_loaded !== 1'b0) begin n_fail++; $display("FAIL async reset flags: got wr=%b busy=%b kl=%b expected 0", fifo_wr, busy, k_loaded); end
      step(); step();
      reset = 1'b1;
      for (int n = 0; n < 8; n++) begin
         #1;
         n_tests++; if (fifo_wr !== 4'b0000 || busy !== 1'b0) begin n_fail++; $display("FAIL post-reset strobe n%0d: got wr=%b busy=%b expected 0", n, fifo_wr, busy); end
         step();
      end
   endtask

   task automatic test_load_wrap();
      for (int v = 1; v <= 5; v++) load_vec(8'(v));
      n_tests++; if (k_loaded !== 1'b1) begin n_fail++; $display("FAIL wrap k_loaded: got %b expected 1", k_loaded); end
      load_vec(8'd7);
      exec_one(8'd1, 1'b0);
      n_tests++; if (got_val[0] !== 22'd40) begin n_fail++; $display("FAIL wrap col0: got %0d expected 40", got_val[0]); end
      n_tests++; if (got_val[1] !== 22'd56) begin n_fail++; $display("FAIL wrap col1: got %0d expected 56", got_val[1]); end
      n_tests++; if (got_val[2] !== 22'd24 || got_val[3] !== 22'd32) begin n_fail++; $display("FAIL wrap col2/3: got %0d/%0d expected 24/32", got_val[2], got_val[3]); end
   endtask

   task automatic test_load_busy();
      drive(2'b10, 8'd1, 1'b0);
      step();
      drive(2'b01, 8'd9, 1'b0);
      #1;
      n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL busy during exec: got %b expected 1", busy); end
      step();
      drive(2'b00, 8'd0, 1'b0);
      for (int n = 0; n < 8; n++) step();
      load_vec(8'd6);
      exec_one(8'd1, 1'b0);
      n_tests++; if (got_val[0] !== 22'd40 || got_val[1] !== 22'd56) begin n_fail++; $display("FAIL busy load col0/1: got %0d/%0d expected 40/56", got_val[0], got_val[1]); end
      n_tests++; if (got_val[2] !== 22'd48) begin n_fail++; $display("FAIL busy load ptr col2: got %0d expected 48", got_val[2]); end
      n_tests++; if (got_val[3] !== 22'd32) begin n_fail++; $display("FAIL busy load col3: got %0d expected 32", got_val[3]); end
   endtask

   initial begin
      test_reset();
      test_load_exec();
      test_signed();
      test_accumulate();
      test_back_to_back_stall();
      test_reset_midstream();
      test_load_wrap();
      test_load_busy();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
